// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions,
// opcode / ALU operation codes and the register-field select encoding.
// Used by fetch_decode and instr_decoder.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // Instruction field bit positions (msb/lsb pairs).
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int ALU_MSB   = 12;
  localparam int ALU_LSB   = 11;
  localparam int RN_MSB    = 10;
  localparam int RN_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int SHIFT_MSB = 4;
  localparam int SHIFT_LSB = 3;
  localparam int RM_MSB    = 2;
  localparam int RM_LSB    = 0;
  localparam int IMM8_MSB  = 7;
  localparam int IMM5_MSB  = 4;

  typedef enum logic [2:0] {
    OPC_BRANCH = 3'b001,
    OPC_BL     = 3'b010,
    OPC_LDR    = 3'b011,
    OPC_STR    = 3'b100,
    OPC_ALU    = 3'b101,
    OPC_MOVE   = 3'b110,
    OPC_HALT   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  // Which instruction register field drives r_addr.
  typedef enum logic [1:0] {
    SEL_RM   = 2'b00,
    SEL_RD   = 2'b01,
    SEL_RN   = 2'b10,
    SEL_ZERO = 2'b11
  } reg_sel_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   ir       in  16  instruction register contents
//   reg_sel  in  2   register-field select (rm / rd / rn / zero)
//   opcode   out 3   ir[15:13]
//   ALU_op   out 2   ir[12:11]
//   shift_op out 2   ir[4:3]
//   r_addr   out 3   selected register number
//   sximm5   out 16  sign-extended ir[4:0]
//   sximm8   out 16  sign-extended ir[7:0]
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  input  logic [1:0]         reg_sel,
  output logic [2:0]         opcode,
  output logic [1:0]         ALU_op,
  output logic [1:0]         shift_op,
  output logic [2:0]         r_addr,
  output logic [INSTR_W-1:0] sximm5,
  output logic [INSTR_W-1:0] sximm8
);

  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;

  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign ALU_op   = ir[ALU_MSB:ALU_LSB];
  assign shift_op = ir[SHIFT_MSB:SHIFT_LSB];
  assign rn       = ir[RN_MSB:RN_LSB];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign rm       = ir[RM_MSB:RM_LSB];

  assign sximm8 = {{(INSTR_W-IMM8_MSB-1){ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};
  assign sximm5 = {{(INSTR_W-IMM5_MSB-1){ir[IMM5_MSB]}}, ir[IMM5_MSB:0]};

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves r_addr unassigned (which would infer a latch).
  always_comb begin
    r_addr = 3'b000;
    case (reg_sel_e'(reg_sel))
      SEL_RN:   r_addr = rn;
      SEL_RD:   r_addr = rd;
      SEL_RM:   r_addr = rm;
      default:  r_addr = 3'b000;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: program counter, instruction register and data-address
// register, RAM address mux, and the instruction decoder.
// Optional feature: define FETCH_PC_TRAP_EN to saturate the PC at 8'hFF and
// raise a sticky pc_trap flag instead of wrapping to 8'h00.
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   load_pc        PC update enable; clear_pc selects PC=0 instead of PC+1
//   load_ir        capture ram_rdata into ir
//   load_addr      capture datapath_out[7:0] into the data-address register
//   sel_addr       ram_addr source: 1 = pc, 0 = data address
//   reg_sel        register-field select for r_addr
//   ram_rdata      RAM read data (one cycle after ram_addr)
//   datapath_out   datapath result, source of the data address
//   ram_addr, pc, ir, opcode, ALU_op, shift_op, r_addr, sximm5, sximm8
//   pc_trap        sticky PC-overflow flag (0 unless FETCH_PC_TRAP_EN)
module fetch_decode
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_pc,
  input  logic               clear_pc,
  input  logic               load_ir,
  input  logic               load_addr,
  input  logic               sel_addr,
  input  logic [1:0]         reg_sel,
  input  logic [INSTR_W-1:0] ram_rdata,
  input  logic [INSTR_W-1:0] datapath_out,
  output logic [PC_W-1:0]    ram_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [2:0]         opcode,
  output logic [1:0]         ALU_op,
  output logic [1:0]         shift_op,
  output logic [2:0]         r_addr,
  output logic [INSTR_W-1:0] sximm5,
  output logic [INSTR_W-1:0] sximm8,
  output logic               pc_trap
);

  logic [PC_W-1:0] data_addr;
  logic [PC_W-1:0] pc_next;

`ifdef FETCH_PC_TRAP_EN
  logic trap_q;
  logic trap_next;

  // Incrementing from the last address saturates and latches the trap;
  // only a clearing PC load releases it.
  always_comb begin
    pc_next   = pc;
    trap_next = trap_q;
    if (load_pc) begin
      if (clear_pc) begin
        pc_next   = '0;
        trap_next = 1'b0;
      end else if (pc == {PC_W{1'b1}}) begin
        trap_next = 1'b1;
      end else begin
        pc_next = pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_next;
  end

  assign pc_trap = trap_q;
`else
  // Increment wraps naturally from the last address back to zero.
  always_comb begin
    pc_next = pc;
    if (load_pc) pc_next = clear_pc ? '0 : pc + 1'b1;
  end

  assign pc_trap = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; ir therefore captures the data for the address
  // presented before a simultaneous pc/data-address update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      data_addr <= '0;
    end else begin
      pc <= pc_next;
      if (load_ir)   ir        <= ram_rdata;
      if (load_addr) data_addr <= datapath_out[PC_W-1:0];
    end
  end

  assign ram_addr = sel_addr ? pc : data_addr;

  instr_decoder u_decoder (
    .ir       (ir),
    .reg_sel  (reg_sel),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .shift_op (shift_op),
    .r_addr   (r_addr),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

endmodule

// File: tb/tb_fetch_decode.sv
// Directed testbench for fetch_decode. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point, away from the edge.
// A small RAM model with one-cycle read latency supplies ram_rdata when
// use_ram is set; otherwise the bench drives ram_rdata directly.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_pc;
  logic        clear_pc;
  logic        load_ir;
  logic        load_addr;
  logic        sel_addr;
  logic [1:0]  reg_sel;
  logic [15:0] ram_rdata;
  logic [15:0] datapath_out;
  logic [7:0]  ram_addr;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op;
  logic [1:0]  shift_op;
  logic [2:0]  r_addr;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic        pc_trap;

  logic        use_ram;
  logic [15:0] ram_drv;
  logic [15:0] ram_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_pc      (load_pc),
    .clear_pc     (clear_pc),
    .load_ir      (load_ir),
    .load_addr    (load_addr),
    .sel_addr     (sel_addr),
    .reg_sel      (reg_sel),
    .ram_rdata    (ram_rdata),
    .datapath_out (datapath_out),
    .ram_addr     (ram_addr),
    .pc           (pc),
    .ir           (ir),
    .opcode       (opcode),
    .ALU_op       (ALU_op),
    .shift_op     (shift_op),
    .r_addr       (r_addr),
    .sximm5       (sximm5),
    .sximm8       (sximm8),
    .pc_trap      (pc_trap)
  );

  // RAM contents: high byte is address ^ 8'h5A, low byte is the address.
  function automatic logic [15:0] ram_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  always @(posedge clk) ram_q <= ram_word(ram_addr);

  assign ram_rdata = use_ram ? ram_q : ram_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    load_pc   = 1'b0;
    clear_pc  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
  endtask

  initial begin
    // Reset with every load asserted: loads must be overridden.
    rst_n        = 1'b0;
    load_pc      = 1'b1;
    clear_pc     = 1'b0;
    load_ir      = 1'b1;
    load_addr    = 1'b1;
    sel_addr     = 1'b0;
    reg_sel      = 2'b00;
    use_ram      = 1'b0;
    ram_drv      = 16'hBEEF;
    datapath_out = 16'hFFFF;
    tick();
    check("rst_pc",       {8'h00, pc}, 16'h0000);
    check("rst_ir",       ir, 16'h0000);
    check("rst_trap",     {15'h0, pc_trap}, 16'h0000);
    check("rst_daddr",    {8'h00, ram_addr}, 16'h0000);
    check("rst_opcode",   {13'h0, opcode}, 16'h0000);
    check("rst_alu_op",   {14'h0, ALU_op}, 16'h0000);
    check("rst_shift_op", {14'h0, shift_op}, 16'h0000);
    check("rst_sximm5",   sximm5, 16'h0000);
    check("rst_sximm8",   sximm8, 16'h0000);
    check("rst_r_addr",   {13'h0, r_addr}, 16'h0000);

    // Three increments from zero.
    rst_n = 1'b1;
    idle();
    sel_addr = 1'b1;
    load_pc  = 1'b1;
    tick();
    tick();
    tick();
    check("inc3_pc",   {8'h00, pc}, 16'h0003);
    check("inc3_addr", {8'h00, ram_addr}, 16'h0003);

    // clear_pc without load_pc has no effect.
    idle();
    clear_pc = 1'b1;
    tick();
    check("clear_no_load_pc", {8'h00, pc}, 16'h0003);

    // Instruction capture and decode: 16'hA0F3.
    idle();
    ram_drv = 16'hA0F3;
    load_ir = 1'b1;
    tick();
    idle();
    ram_drv = 16'h1111;
    check("ir_a0f3",     ir, 16'hA0F3);
    check("opcode_a0f3", {13'h0, opcode}, 16'h0005);
    check("alu_a0f3",    {14'h0, ALU_op}, 16'h0000);
    check("shift_a0f3",  {14'h0, shift_op}, 16'h0002);
    check("sximm8_a0f3", sximm8, 16'hFFF3);
    check("sximm5_a0f3", sximm5, 16'hFFF3);
    reg_sel = 2'b10; #1;
    check("rn_a0f3", {13'h0, r_addr}, 16'h0000);
    reg_sel = 2'b01; #1;
    check("rd_a0f3", {13'h0, r_addr}, 16'h0007);
    reg_sel = 2'b00; #1;
    check("rm_a0f3", {13'h0, r_addr}, 16'h0003);
    tick();
    check("ir_hold", ir, 16'hA0F3);

    // Second pattern with positive immediates: 16'h4A6C.
    ram_drv = 16'h4A6C;
    load_ir = 1'b1;
    tick();
    idle();
    check("opcode_4a6c", {13'h0, opcode}, 16'h0002);
    check("alu_4a6c",    {14'h0, ALU_op}, 16'h0001);
    check("shift_4a6c",  {14'h0, shift_op}, 16'h0001);
    check("sximm8_4a6c", sximm8, 16'h006C);
    check("sximm5_4a6c", sximm5, 16'h000C);
    reg_sel = 2'b10; #1;
    check("rn_4a6c", {13'h0, r_addr}, 16'h0002);
    reg_sel = 2'b01; #1;
    check("rd_4a6c", {13'h0, r_addr}, 16'h0003);
    reg_sel = 2'b00; #1;
    check("rm_4a6c", {13'h0, r_addr}, 16'h0004);
    reg_sel = 2'b11; #1;
    check("zero_4a6c", {13'h0, r_addr}, 16'h0000);

    // Data address capture and address mux.
    datapath_out = 16'h1234;
    load_addr    = 1'b1;
    tick();
    idle();
    sel_addr = 1'b0; #1;
    check("daddr_34", {8'h00, ram_addr}, 16'h0034);
    sel_addr = 1'b1; #1;
    check("addr_pc", {8'h00, ram_addr}, 16'h0003);

    // Clear then walk to pc=5, wait one cycle for RAM, then load all three.
    load_pc  = 1'b1;
    clear_pc = 1'b1;
    tick();
    check("clear_pc", {8'h00, pc}, 16'h0000);
    clear_pc = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    idle();
    use_ram = 1'b1;
    check("pc_5", {8'h00, pc}, 16'h0005);
    tick();
    load_pc      = 1'b1;
    load_ir      = 1'b1;
    load_addr    = 1'b1;
    datapath_out = 16'h77AB;
    tick();
    idle();
    check("all_pc", {8'h00, pc}, 16'h0006);
    check("all_ir", ir, 16'h5F05);
    sel_addr = 1'b0; #1;
    check("all_daddr", {8'h00, ram_addr}, 16'h00AB);
    sel_addr = 1'b1;

    // Reset mid-operation, loads asserted.
    rst_n     = 1'b0;
    load_pc   = 1'b1;
    load_ir   = 1'b1;
    load_addr = 1'b1;
    tick();
    rst_n = 1'b1;
    idle();
    check("mid_rst_pc", {8'h00, pc}, 16'h0000);
    check("mid_rst_ir", ir, 16'h0000);
    sel_addr = 1'b0; #1;
    check("mid_rst_daddr", {8'h00, ram_addr}, 16'h0000);
    sel_addr = 1'b1;

    // Walk to the last address, then step past it.
    load_pc = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("pc_ff", {8'h00, pc}, 16'h00FF);
    check("trap_before", {15'h0, pc_trap}, 16'h0000);
    tick();
`ifdef FETCH_PC_TRAP_EN
    check("ovf_pc",   {8'h00, pc}, 16'h00FF);
    check("ovf_trap", {15'h0, pc_trap}, 16'h0001);
    tick();
    check("ovf_sticky_pc",   {8'h00, pc}, 16'h00FF);
    check("ovf_sticky_trap", {15'h0, pc_trap}, 16'h0001);
`else
    check("ovf_pc",   {8'h00, pc}, 16'h0000);
    check("ovf_trap", {15'h0, pc_trap}, 16'h0000);
    tick();
    check("wrap_next_pc",   {8'h00, pc}, 16'h0001);
    check("wrap_next_trap", {15'h0, pc_trap}, 16'h0000);
`endif
    clear_pc = 1'b1;
    tick();
    idle();
    check("release_pc",   {8'h00, pc}, 16'h0000);
    check("release_trap", {15'h0, pc_trap}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have port load_pc, input, 1, PC update enable from controller.
REQ-004 SHALL have port clear_pc, input, 1, selects PC=0 when load_pc=1.
REQ-005 SHALL have port load_ir, input, 1, IR capture enable.
REQ-006 SHALL have port load_addr, input, 1, data-address register capture enable.
REQ-007 SHALL have port sel_addr, input, 1, RAM address select: 1 = PC, 0 = data address.
REQ-008 SHALL have port reg_sel, input, 2, register-field select for r_addr.
REQ-009 SHALL have port ram_rdata, input, 16, RAM read data, valid one cycle after ram_addr.
REQ-010 SHALL have port datapath_out, input, 16, datapath result, source for the data address.
REQ-011 SHALL have port ram_addr, output, 8, RAM address.
REQ-012 SHALL have port pc, output, 8, current program counter.
REQ-013 SHALL have port ir, output, 16, instruction register.
REQ-014 SHALL have ports opcode (3), ALU_op (2), shift_op (2), outputs, decoded IR fields.
REQ-015 SHALL have port r_addr, output, 3, selected register number.
REQ-016 SHALL have ports sximm5 and sximm8, outputs, 16 each, sign-extended immediates.
REQ-017 SHALL have port pc_trap, output, 1, sticky PC-overflow flag (see Configuration).

Function
REQ-018 SHALL, on a clk edge with load_pc=1, load pc with 8'h00 if clear_pc=1, else pc+1; load_pc=0 SHALL hold pc regardless of clear_pc.
REQ-019 SHALL, on a clk edge with load_ir=1, load ir with ram_rdata; otherwise hold ir.
REQ-020 SHALL, on a clk edge with load_addr=1, load the data-address register with datapath_out[7:0].
REQ-021 SHALL drive ram_addr combinationally: pc when sel_addr=1, data-address register when sel_addr=0.
REQ-022 SHALL decode from ir combinationally: opcode=ir[15:13], ALU_op=ir[12:11], shift_op=ir[4:3], rn=ir[10:8], rd=ir[7:5], rm=ir[2:0].
REQ-023 SHALL drive r_addr: reg_sel 2'b10 -> rn, 2'b01 -> rd, 2'b00 -> rm, 2'b11 -> 3'b000.
REQ-024 SHALL drive sximm8 = sign extension of ir[7:0] and sximm5 = sign extension of ir[4:0].
REQ-025 SHALL handle load_pc, load_ir and load_addr asserted together: all three update on the same edge; ir captures ram_rdata of the pre-edge address.
REQ-026 SHALL present the new pc on ram_addr (sel_addr=1) in the cycle after a load_pc edge; the instruction is capturable by load_ir one cycle later (one-cycle RAM latency).

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, set pc=8'h00, ir=16'h0000, data-address register=8'h00, pc_trap=0, overriding all load inputs.
REQ-028 SHALL, with ir=0 after reset, output opcode=0, ALU_op=0, shift_op=0, sximm5=0, sximm8=0, r_addr=0 for reg_sel=2'b00.
REQ-029 SHALL apply reset mid-operation on the next edge with no partial update of any register.

Configuration
REQ-030 SHALL, with macro FETCH_PC_TRAP_EN defined, on load_pc=1, clear_pc=0, pc=8'hFF: hold pc at 8'hFF and set pc_trap=1, sticky until reset or load_pc=1 with clear_pc=1.
REQ-031 SHALL, without FETCH_PC_TRAP_EN, wrap pc from 8'hFF to 8'h00 and tie pc_trap to 0.

Structure
REQ-032 SHALL take opcode/ALU_op constants, IR field bit positions, and PC_W=8 / INSTR_W=16 from shared package cpu_pkg.
REQ-033 SHALL implement field extraction, sign extension and r_addr mux in sub-module instr_decoder (combinational); registers SHALL live in fetch_decode.

Verification
REQ-034 SHALL cover: rst_n=0 one edge with all loads=1 -> pc=0, ir=0, pc_trap=0.
REQ-035 SHALL cover: load_pc=1, clear_pc=0 for 3 edges from 0 -> pc=3, ram_addr=3 with sel_addr=1; clear_pc=1 alone (load_pc=0) -> pc stays 3.
REQ-036 SHALL cover: ram_rdata=16'hA0F3, load_ir edge -> opcode=3'b101, ALU_op=2'b00, rn=0, sximm8=16'hFFF3, sximm5=16'hFFF3; reg_sel=2'b01 -> r_addr=3'b111.
REQ-037 SHALL cover: datapath_out=16'h1234, load_addr edge, sel_addr=0 -> ram_addr=8'h34; sel_addr=1 -> ram_addr=pc.
REQ-038 SHALL cover: pc=8'hFF, load_pc=1 -> with FETCH_PC_TRAP_EN pc=8'hFF, pc_trap=1; without it pc=8'h00, pc_trap=0.
REQ-039 SHALL cover: load_pc, load_ir, load_addr together at pc=5 -> pc=6, ir=RAM[5], data-address=datapath_out[7:0].
